// File: rtl/csc.sv
// Three-stage colour-space converter (RGB->YUV, YUV->RGB, pass-through) on the 27-bit pixel bus.
// Build option: define CSC_ROUND_EN for round-to-nearest (rc = 128); otherwise rc = 0 (floor).
module csc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  Mode,
    input  logic [26:0] DPi,
    output logic [26:0] DPo
);

`ifdef CSC_ROUND_EN
    localparam logic signed [19:0] RC = 20'sd128;
`else
    localparam logic signed [19:0] RC = 20'sd0;
`endif

    // Stage 1: input capture
    logic [2:0]  s1_flags_q;
    logic [23:0] s1_pix_q;
    logic [1:0]  s1_mode_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_flags_q <= '0;
            s1_pix_q   <= '0;
            s1_mode_q  <= '0;
        end else begin
            s1_flags_q <= DPi[26:24];
            s1_pix_q   <= DPi[23:0];
            s1_mode_q  <= Mode;
        end
    end

    // Stage 2: products and sums; the per-channel offset travels as a base term
    logic signed [19:0] c0, c1, c2, u, v;
    logic signed [19:0] s2_prod_d [3];
    logic signed [19:0] s2_base_d [3];
    logic signed [19:0] s2_prod_q [3];
    logic signed [19:0] s2_base_q [3];
    logic [2:0]         s2_flags_q;

    assign c0 = $signed({12'd0, s1_pix_q[23:16]});
    assign c1 = $signed({12'd0, s1_pix_q[15:8]});
    assign c2 = $signed({12'd0, s1_pix_q[7:0]});
    assign u  = c1 - 20'sd128;
    assign v  = c2 - 20'sd128;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            s2_prod_d[i] = '0;
            s2_base_d[i] = '0;
        end
        case (s1_mode_q)
            2'b00: begin
                s2_prod_d[0] = 20'sd77 * c0 + 20'sd150 * c1 + 20'sd29 * c2;
                s2_prod_d[1] = -20'sd43 * c0 - 20'sd85 * c1 + 20'sd128 * c2;
                s2_prod_d[2] = 20'sd128 * c0 - 20'sd107 * c1 - 20'sd21 * c2;
                s2_base_d[1] = 20'sd128;
                s2_base_d[2] = 20'sd128;
            end
            2'b01: begin
                s2_prod_d[0] = 20'sd359 * v;
                s2_prod_d[1] = -20'sd88 * u - 20'sd183 * v;
                s2_prod_d[2] = 20'sd454 * u;
                s2_base_d[0] = c0;
                s2_base_d[1] = c0;
                s2_base_d[2] = c0;
            end
            default: begin
                // Zero product shifts to zero for either rc, so the base carries the pixel unchanged
                s2_base_d[0] = c0;
                s2_base_d[1] = c1;
                s2_base_d[2] = c2;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_flags_q <= '0;
            for (int i = 0; i < 3; i++) begin
                s2_prod_q[i] <= '0;
                s2_base_q[i] <= '0;
            end
        end else begin
            s2_flags_q <= s1_flags_q;
            for (int i = 0; i < 3; i++) begin
                s2_prod_q[i] <= s2_prod_d[i];
                s2_base_q[i] <= s2_base_d[i];
            end
        end
    end

    // Stage 3: round, shift, offset and clamp
    logic [7:0]  chan [3];
    logic [26:0] dpo_d, dpo_q;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic signed [19:0] sum;
            assign sum = ((s2_prod_q[gi] + RC) >>> 8) + s2_base_q[gi];
            assign chan[gi] = (sum < 20'sd0)   ? 8'h00 :
                              (sum > 20'sd255) ? 8'hFF : sum[7:0];
        end
    endgenerate

    assign dpo_d = {s2_flags_q, chan[0], chan[1], chan[2]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dpo_q <= '0;
        end else begin
            dpo_q <= dpo_d;
        end
    end

    assign DPo = dpo_q;

endmodule

// File: tb/tb_csc.sv
// Self-checking bench for csc: directed golden vectors, randomized pixels vs. arithmetic model, scaled frame.
// Honours CSC_ROUND_EN the same way as the design.
module tb_csc;

    logic        clk;
    logic        rst_n;
    logic [1:0]  Mode;
    logic [26:0] DPi;
    logic [26:0] DPo;

    csc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Mode  (Mode),
        .DPi   (DPi),
        .DPo   (DPo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CSC_ROUND_EN
    localparam int          RC_TB = 128;
    localparam logic [7:0]  Y_RED = 8'h4D;
`else
    localparam int          RC_TB = 0;
    localparam logic [7:0]  Y_RED = 8'h4C;
`endif

    int n_vec = 0;
    int n_err = 0;
    int de_in = 0;
    int de_out = 0;

    logic [26:0] eq[$];
    string       tq[$];

    function automatic logic [7:0] clamp8(input int x);
        if (x < 0)   return 8'h00;
        if (x > 255) return 8'hFF;
        return x[7:0];
    endfunction

    // Reference conversion straight from the channel equations
    function automatic logic [26:0] model(input logic [1:0] m, input logic [26:0] d);
        int a, b, c, uu, vv;
        logic [7:0] o0, o1, o2;
        a = int'(d[23:16]);
        b = int'(d[15:8]);
        c = int'(d[7:0]);
        case (m)
            2'b00: begin
                o0 = clamp8((77*a + 150*b + 29*c + RC_TB) >>> 8);
                o1 = clamp8(((-43*a - 85*b + 128*c + RC_TB) >>> 8) + 128);
                o2 = clamp8(((128*a - 107*b - 21*c + RC_TB) >>> 8) + 128);
            end
            2'b01: begin
                uu = b - 128;
                vv = c - 128;
                o0 = clamp8(a + ((359*vv + RC_TB) >>> 8));
                o1 = clamp8(a + ((-88*uu - 183*vv + RC_TB) >>> 8));
                o2 = clamp8(a + ((454*uu + RC_TB) >>> 8));
            end
            default: begin
                o0 = d[23:16];
                o1 = d[15:8];
                o2 = d[7:0];
            end
        endcase
        return {d[26:24], o0, o1, o2};
    endfunction

    task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: DPo=%h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, clock, then compare the output word due after this edge
    task automatic step(input string tag, input logic r, input logic [1:0] m,
                        input logic [26:0] d, input bit use_g, input logic [26:0] g);
        logic [26:0] e;
        string       t;
        rst_n = r;
        Mode  = m;
        DPi   = d;
        @(posedge clk);
        #1;
        if (!r) begin
            eq.delete();
            tq.delete();
            // cleared registers: output stage holds 0, stage 1 holds a zero pixel at mode 00
            eq.push_back(27'h0);
            tq.push_back("after-reset-s3");
            eq.push_back(model(2'b00, 27'h0));
            tq.push_back("after-reset-s1");
            check({"reset-", tag}, DPo, 27'h0);
        end else begin
            eq.push_back(use_g ? g : model(m, d));
            tq.push_back(tag);
            if (d[24]) de_in++;
            e = eq.pop_front();
            t = tq.pop_front();
            check(t, DPo, e);
        end
        if (DPo[24]) de_out++;
    endtask

    initial begin
        logic [26:0] rd;
        logic [1:0]  rm;
        logic [2:0]  fl;

        rst_n = 1'b0;
        Mode  = 2'b00;
        DPi   = '0;

        // Reset held with toggling inputs
        for (int i = 0; i < 5; i++) begin
            rd = 27'($urandom);
            step("hold", 1'b0, 2'($urandom_range(0, 3)), rd, 1'b0, 27'h0);
        end

        // Directed golden vectors (DE=1)
        step("y-white",  1'b1, 2'b00, {3'b001, 24'hFFFFFF}, 1'b1, {3'b001, 24'hFF8080});
        step("y-black",  1'b1, 2'b00, {3'b001, 24'h000000}, 1'b1, {3'b001, 24'h008080});
        step("y-red",    1'b1, 2'b00, {3'b001, 24'hFF0000}, 1'b1, {3'b001, Y_RED, 16'h55FF});
        step("rgb-grey", 1'b1, 2'b01, {3'b001, 24'h808080}, 1'b1, {3'b001, 24'h808080});
        step("rgb-clip", 1'b1, 2'b01, {3'b001, 24'hFF80FF}, 1'b1, {3'b001, 24'hFFA4FF});
        step("pass",     1'b1, 2'b10, {3'b001, 24'h123456}, 1'b1, {3'b001, 24'h123456});
        step("flags101", 1'b1, 2'b10, {3'b101, 24'hA5A5A5}, 1'b1, {3'b101, 24'hA5A5A5});
        step("flags011", 1'b1, 2'b10, {3'b011, 24'h5A5A5A}, 1'b1, {3'b011, 24'h5A5A5A});
        step("flags001", 1'b1, 2'b11, {3'b001, 24'h0F0F0F}, 1'b1, {3'b001, 24'h0F0F0F});
        step("sw-yuv",   1'b1, 2'b00, {3'b001, 24'hFFFFFF}, 1'b1, {3'b001, 24'hFF8080});
        step("sw-pass",  1'b1, 2'b10, {3'b001, 24'hFFFFFF}, 1'b1, {3'b001, 24'hFFFFFF});
        for (int i = 0; i < 3; i++)
            step("drain", 1'b1, 2'b10, 27'h0, 1'b0, 27'h0);

        // Randomized stream with a mid-stream reset
        for (int i = 0; i < 1500; i++) begin
            rd = 27'($urandom);
            rm = 2'($urandom_range(0, 3));
            if (i == 700 || i == 701)
                step("mid", 1'b0, rm, rd, 1'b0, 27'h0);
            else
                step("rand", 1'b1, rm, rd, 1'b0, 27'h0);
        end
        for (int i = 0; i < 3; i++)
            step("drain", 1'b1, 2'b00, 27'h0, 1'b0, 27'h0);

        // Scaled frame: 64x24 active, with horizontal and vertical blanking
        de_in  = 0;
        de_out = 0;
        for (int ln = 0; ln < 28; ln++) begin
            for (int px = 0; px < 80; px++) begin
                fl[2] = (ln >= 24);
                fl[1] = (px >= 68 && px < 72);
                fl[0] = (ln < 24 && px < 64);
                rd = {fl, 24'($urandom)};
                step("frame", 1'b1, 2'($urandom_range(0, 3)), rd, 1'b0, 27'h0);
            end
        end
        for (int i = 0; i < 3; i++)
            step("drain", 1'b1, 2'b00, 27'h0, 1'b0, 27'h0);

        n_vec++;
        assert (de_out === 1536 && de_in === 1536)
        else begin
            n_err++;
            $error("FAIL de-count: in=%0d out=%0d expected 1536", de_in, de_out);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
